lfsr_stream_decrypt: RTL and testbench

Receive-side counterpart of the LFSR keystream encryptor. It regenerates the identical 8-bit keystream from a shared seed and XORs it with incoming ciphertext bytes to recover plaintext. Ciphertext and plaintext each use a valid/ready handshake. Operation is framed: after FRAME_LEN bytes the block returns to idle and waits for a fresh seed (rekey).

---
 rtl/lfsr_stream_decrypt.sv | 140 ++++++++++++++
 tb/tb_lfsr_stream_decrypt.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_decrypt.sv
// LFSR keystream decryptor: regenerates the encryptor's 8-bit keystream from a
// shared seed and XORs it onto framed ciphertext bytes to recover plaintext.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   seed, load_seed       keystream seed and single-cycle frame-start pulse
//   in_data/valid/ready   ciphertext stream (valid/ready handshake)
//   out_data/valid/ready  plaintext stream (valid/ready handshake)
//   out_last              marks the final plaintext byte of a frame
//   busy                  high while a frame is running or draining
//   byte_count            ciphertext bytes accepted in the current frame
module lfsr_stream_decrypt #(
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    input  logic       load_seed,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic [7:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic [7:0] cnt_q, cnt_d;

    logic [7:0] seed_fix;
    logic [7:0] lfsr_step;
    logic       accept;
    logic       drain;

    // A zero seed would lock the LFSR at zero, so it is remapped to 1.
    assign seed_fix  = (seed == 8'h00) ? 8'h01 : seed;
    assign lfsr_step = {lfsr_q[6:0],
                        lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        drain       = out_valid_q && out_ready;

        unique case (state_q)
            IDLE: begin
                if (load_seed) begin
                    lfsr_d  = seed_fix;
                    cnt_d   = 8'd0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (load_seed) begin
                    // Rekey wins over input; any pending byte stays put.
                    lfsr_d     = seed_fix;
                    cnt_d      = 8'd0;
                    out_last_d = 1'b0;
                    if (drain) begin
                        out_valid_d = 1'b0;
                    end
                end else begin
                    in_ready = !out_valid_q || out_ready;
                    accept   = in_valid && in_ready;
                    if (accept) begin
                        out_data_d  = in_data ^ lfsr_q;
                        out_valid_d = 1'b1;
                        lfsr_d      = lfsr_step;
                        cnt_d       = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == FRAME_LEN_B) begin
                            out_last_d = 1'b1;
                            state_d    = DRAIN;
                        end
                    end else if (drain) begin
                        out_valid_d = 1'b0;
                    end
                end
            end

            DRAIN: begin
                if (drain) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= 8'h01;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign byte_count = cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Self-checking bench for lfsr_stream_decrypt: a 16-byte-frame instance (a_*)
// and a 4-byte-frame instance (b_*) share all inputs.
module tb_lfsr_stream_decrypt;

    localparam int FL_A = 16;
    localparam int FL_B = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] seed;
    logic       load_seed;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0] a_out_data, a_cnt;
    logic       b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [7:0] b_out_data, b_cnt;

    int checks = 0;
    int errors = 0;

    lfsr_stream_decrypt #(.FRAME_LEN(FL_A)) u_a (
        .clk(clk), .rst_n(rst_n), .seed(seed), .load_seed(load_seed),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_last(a_out_last), .busy(a_busy),
        .byte_count(a_cnt)
    );

    lfsr_stream_decrypt #(.FRAME_LEN(FL_B)) u_b (
        .clk(clk), .rst_n(rst_n), .seed(seed), .load_seed(load_seed),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_last(b_out_last), .busy(b_busy),
        .byte_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keystream byte n of a frame started with seed s (n=0 is the seed itself).
    function automatic logic [7:0] ks_at(input logic [7:0] s, input int n);
        logic [7:0] r;
        r = (s == 8'h00) ? 8'h01 : s;
        for (int k = 0; k < n; k++) begin
            r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        load_seed = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        seed      = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [7:0] s);
        seed      = s;
        load_seed = 1'b1;
        tick();
        load_seed = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        load_seed = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        seed      = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        checks += 6;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid);
        end
        if (a_out_data !== 8'h00) begin
            errors++; $display("FAIL reset_out_data got %h exp 00", a_out_data);
        end
        if (a_out_last !== 1'b0) begin
            errors++; $display("FAIL reset_out_last got %b exp 0", a_out_last);
        end
        if (a_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", a_busy);
        end
        if (a_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", a_cnt);
        end
        if (a_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b exp 0", a_in_ready);
        end
        rst_n = 1'b1;
        // Idle ignores ciphertext until a seed is loaded.
        in_valid = 1'b1;
        in_data  = 8'h55;
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_no_accept got %b exp 0", a_out_valid);
        end
        if (a_in_ready !== 1'b0) begin
            errors++; $display("FAIL idle_in_ready got %b exp 0", a_in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] ct [6];
        logic [7:0] ks_exp [6];
        ct     = '{8'h41, 8'h42, 8'h44, 8'h48, 8'h51, 8'h63};
        ks_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        do_reset();
        out_ready = 1'b1;
        do_load(8'h01);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ks_at(8'h01, i) !== ks_exp[i]) begin
                errors++;
                $display("FAIL model_ks%0d got %h exp %h", i, ks_at(8'h01, i), ks_exp[i]);
            end
            in_valid = 1'b1;
            in_data  = ct[i];
            #1;
            checks++;
            if (a_in_ready !== 1'b1) begin
                errors++; $display("FAIL basic_in_ready%0d got %b exp 1", i, a_in_ready);
            end
            tick();
            checks += 3;
            if (a_out_valid !== 1'b1) begin
                errors++; $display("FAIL basic_valid%0d got %b exp 1", i, a_out_valid);
            end
            if (a_out_data !== 8'h40) begin
                errors++; $display("FAIL basic_data%0d got %h exp 40", i, a_out_data);
            end
            if (a_cnt !== 8'(i + 1)) begin
                errors++; $display("FAIL basic_count%0d got %0d exp %0d", i, a_cnt, i + 1);
            end
        end
        in_valid = 1'b0;
        tick();
        checks += 2;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle_valid got %b exp 0", a_out_valid);
        end
        if (a_cnt !== 8'd6) begin
            errors++; $display("FAIL basic_final_count got %0d exp 6", a_cnt);
        end
    endtask

    task automatic test_zero_seed();
        do_reset();
        out_ready = 1'b1;
        do_load(8'h00);
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (a_out_data !== 8'h00) begin
            errors++; $display("FAIL zero_seed_data got %h exp 00", a_out_data);
        end
        if (a_busy !== 1'b1) begin
            errors++; $display("FAIL zero_seed_busy got %b exp 1", a_busy);
        end
    endtask

    task automatic test_frame();
        logic [7:0] ct [5];
        for (int i = 0; i < 5; i++) ct[i] = 8'($urandom);
        do_reset();
        out_ready = 1'b1;
        do_load(8'h01);
        for (int i = 0; i < FL_B; i++) begin
            in_valid = 1'b1;
            in_data  = ct[i];
            tick();
            checks += 2;
            if (b_out_data !== (ct[i] ^ ks_at(8'h01, i))) begin
                errors++;
                $display("FAIL frame_data%0d got %h exp %h", i, b_out_data, ct[i] ^ ks_at(8'h01, i));
            end
            if (b_out_last !== (i == FL_B - 1)) begin
                errors++; $display("FAIL frame_last%0d got %b exp %b", i, b_out_last, i == FL_B - 1);
            end
        end
        in_data = ct[4];
        #1;
        checks += 2;
        if (b_busy !== 1'b1) begin
            errors++; $display("FAIL frame_drain_busy got %b exp 1", b_busy);
        end
        if (b_in_ready !== 1'b0) begin
            errors++; $display("FAIL frame_drain_ready got %b exp 0", b_in_ready);
        end
        tick();
        tick();
        checks += 4;
        if (b_out_valid !== 1'b0) begin
            errors++; $display("FAIL frame_idle_valid got %b exp 0", b_out_valid);
        end
        if (b_busy !== 1'b0) begin
            errors++; $display("FAIL frame_idle_busy got %b exp 0", b_busy);
        end
        if (b_in_ready !== 1'b0) begin
            errors++; $display("FAIL frame_idle_ready got %b exp 0", b_in_ready);
        end
        if (b_cnt !== 8'd4) begin
            errors++; $display("FAIL frame_idle_count got %0d exp 4", b_cnt);
        end
        seed      = 8'h33;
        load_seed = 1'b1;
        #1;
        checks++;
        if (b_in_ready !== 1'b0) begin
            errors++; $display("FAIL frame_load_ready got %b exp 0", b_in_ready);
        end
        tick();
        load_seed = 1'b0;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++; $display("FAIL frame_rerun_ready got %b exp 1", b_in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (b_out_data !== (ct[4] ^ 8'h33)) begin
            errors++; $display("FAIL frame_fifth_data got %h exp %h", b_out_data, ct[4] ^ 8'h33);
        end
        if (b_cnt !== 8'd1) begin
            errors++; $display("FAIL frame_fifth_count got %0d exp 1", b_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s, c0, c1, e0;
        s  = 8'($urandom_range(1, 255));
        c0 = 8'($urandom);
        c1 = 8'($urandom);
        e0 = c0 ^ ks_at(s, 0);
        do_reset();
        out_ready = 1'b1;
        do_load(s);
        in_valid = 1'b1;
        in_data  = c0;
        tick();
        out_ready = 1'b0;
        in_data   = c1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready%0d got %b exp 0", i, a_in_ready);
            end
            tick();
            checks += 3;
            if (a_out_data !== e0) begin
                errors++; $display("FAIL bp_hold_data%0d got %h exp %h", i, a_out_data, e0);
            end
            if (a_out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_valid%0d got %b exp 1", i, a_out_valid);
            end
            if (a_cnt !== 8'd1) begin
                errors++; $display("FAIL bp_hold_count%0d got %0d exp 1", i, a_cnt);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b exp 1", a_in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (a_out_data !== (c1 ^ ks_at(s, 1))) begin
            errors++; $display("FAIL bp_resume_data got %h exp %h", a_out_data, c1 ^ ks_at(s, 1));
        end
    endtask

    task automatic test_rekey();
        logic [7:0] c [3];
        for (int i = 0; i < 3; i++) c[i] = 8'($urandom);
        do_reset();
        out_ready = 1'b1;
        do_load(8'h01);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = c[i];
            tick();
        end
        in_data   = c[2];
        out_ready = 1'b0;
        seed      = 8'h80;
        load_seed = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++; $display("FAIL rekey_in_ready got %b exp 0", a_in_ready);
        end
        tick();
        load_seed = 1'b0;
        checks += 4;
        if (a_out_valid !== 1'b1) begin
            errors++; $display("FAIL rekey_pending_valid got %b exp 1", a_out_valid);
        end
        if (a_out_data !== (c[1] ^ ks_at(8'h01, 1))) begin
            errors++;
            $display("FAIL rekey_pending_data got %h exp %h", a_out_data, c[1] ^ ks_at(8'h01, 1));
        end
        if (a_out_last !== 1'b0) begin
            errors++; $display("FAIL rekey_pending_last got %b exp 0", a_out_last);
        end
        if (a_cnt !== 8'd0) begin
            errors++; $display("FAIL rekey_count_clear got %0d exp 0", a_cnt);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (a_out_data !== (c[2] ^ 8'h80)) begin
            errors++; $display("FAIL rekey_data got %h exp %h", a_out_data, c[2] ^ 8'h80);
        end
        if (a_cnt !== 8'd1) begin
            errors++; $display("FAIL rekey_count got %0d exp 1", a_cnt);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] pt [32];
        int snd = 0;
        int rcv = 0;
        int cyc = 0;
        for (int i = 0; i < 32; i++) pt[i] = 8'($urandom);
        do_reset();
        while (rcv < 32 && cyc < 3000) begin
            load_seed = 1'b0;
            in_valid  = 1'b0;
            seed      = 8'h5A;
            if (!a_busy && !a_out_valid && snd < 32) begin
                load_seed = 1'b1;
            end else if (snd < 32) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = pt[snd] ^ ks_at(8'h5A, snd % FL_A);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (a_out_valid && out_ready) begin
                checks += 2;
                if (a_out_data !== pt[rcv]) begin
                    errors++; $display("FAIL loop_data%0d got %h exp %h", rcv, a_out_data, pt[rcv]);
                end
                if (a_out_last !== (rcv % FL_A == FL_A - 1)) begin
                    errors++;
                    $display("FAIL loop_last%0d got %b exp %b", rcv, a_out_last, rcv % FL_A == FL_A - 1);
                end
                rcv++;
            end
            if (in_valid && a_in_ready) snd++;
            tick();
            cyc++;
        end
        load_seed = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (rcv != 32) begin
            errors++; $display("FAIL loop_timeout got %0d bytes exp 32", rcv);
        end
        // Asynchronous reset with a byte pending in the output register.
        out_ready = 1'b0;
        do_load(8'h5A);
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++; $display("FAIL loop_pend_valid got %b exp 1", a_out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst_valid got %b exp 0", a_out_valid);
        end
        if (a_busy !== 1'b0) begin
            errors++; $display("FAIL async_rst_busy got %b exp 0", a_busy);
        end
        if (a_cnt !== 8'd0) begin
            errors++; $display("FAIL async_rst_count got %0d exp 0", a_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_seed();
        test_frame();
        test_backpressure();
        test_rekey();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
